// File: rtl/fpu_exec_responder_if.sv
// ---------------------------------------------------------------------------
// fpu_exec_responder_if
//
// Bundle of every signal between the FPU execution responder and the blocks
// around it: FPU decode (issue), the fixed-latency add/mul/fma pipe, the
// iterative div/sqrt unit and the writeback/stall path.
//
//   slave  : view taken by fpu_exec_responder itself
//   master : view taken by the surrounding environment (decode, units, bench)
//
// Signal groups
//   issue_*      / fsN_data : operation request from decode
//   issue_ready             : responder can accept an issue this cycle
//   pipe_*                  : pipelined-unit request and response
//   divsqrt_*               : iterative-unit request and response
//   fpu_*                   : writeback (complete strobe, result, fd, flags)
//   halt_req / busy         : core stall request / responder not idle
// ---------------------------------------------------------------------------
interface fpu_exec_responder_if #(
  parameter int FPLEN = 32
);

  // issue from decode
  logic             issue_valid;
  logic [2:0]       issue_op;
  logic [2:0]       issue_rnd;
  logic [4:0]       issue_fd;
  logic [FPLEN-1:0] fs1_data;
  logic [FPLEN-1:0] fs2_data;
  logic [FPLEN-1:0] fs3_data;
  logic             issue_ready;

  // pipelined add/mul/fma unit
  logic             pipe_start;
  logic [1:0]       pipe_op;
  logic [FPLEN-1:0] pipe_a;
  logic [FPLEN-1:0] pipe_b;
  logic [FPLEN-1:0] pipe_c;
  logic [2:0]       pipe_rnd;
  logic [FPLEN-1:0] pipe_result;
  logic [4:0]       pipe_flags;

  // iterative div/sqrt unit
  logic             divsqrt_start;
  logic             divsqrt_is_sqrt;
  logic             divsqrt_done;
  logic [FPLEN-1:0] divsqrt_result;
  logic [4:0]       divsqrt_flags;

  // writeback and core control
  logic             fpu_complete;
  logic [FPLEN-1:0] fpu_result_1;
  logic [4:0]       fpu_fd;
  logic [4:0]       fpu_flags;
  logic             halt_req;
  logic             busy;

  modport slave (
    input  issue_valid, issue_op, issue_rnd, issue_fd,
    input  fs1_data, fs2_data, fs3_data,
    output issue_ready,
    output pipe_start, pipe_op, pipe_a, pipe_b, pipe_c, pipe_rnd,
    input  pipe_result, pipe_flags,
    output divsqrt_start, divsqrt_is_sqrt,
    input  divsqrt_done, divsqrt_result, divsqrt_flags,
    output fpu_complete, fpu_result_1, fpu_fd, fpu_flags,
    output halt_req, busy
  );

  modport master (
    output issue_valid, issue_op, issue_rnd, issue_fd,
    output fs1_data, fs2_data, fs3_data,
    input  issue_ready,
    input  pipe_start, pipe_op, pipe_a, pipe_b, pipe_c, pipe_rnd,
    output pipe_result, pipe_flags,
    input  divsqrt_start, divsqrt_is_sqrt,
    output divsqrt_done, divsqrt_result, divsqrt_flags,
    input  fpu_complete, fpu_result_1, fpu_fd, fpu_flags,
    input  halt_req, busy
  );

endinterface

// File: rtl/fpu_exec_responder.sv
// ---------------------------------------------------------------------------
// fpu_exec_responder
//
// Sequences one floating-point operation at a time between FPU decode and
// the execution units:
//   - SGNJ/SGNJN/SGNJX are computed locally and complete the cycle after issue
//   - ADD/MUL/FMA are handed to a fixed-latency pipe; the response is sampled
//     exactly PIPE_LAT cycles after the pipe_start cycle
//   - DIV/SQRT are handed to an iterative unit; the responder waits for
//     divsqrt_done, falling back to a canonical NaN with NV after DIV_TIMEOUT
//     cycles, and requests a core halt while waiting
//
// Ports
//   clk  : sole clock, rising edge
//   rst  : synchronous active-high reset (returns to IDLE, clears outputs)
//   bus  : fpu_exec_responder_if.slave (issue, pipe, div/sqrt, writeback)
//
// The div/sqrt unit takes its operands from the pipe_a/pipe_b bus, which is
// registered at issue; for SQRT pipe_b is forced to zero.
// ---------------------------------------------------------------------------
module fpu_exec_responder #(
  parameter int FPLEN       = 32,
  parameter int PIPE_LAT    = 3,
  parameter int DIV_TIMEOUT = 64
) (
  input logic                  clk,
  input logic                  rst,
  fpu_exec_responder_if.slave  bus
);

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_MUL   = 3'd1;
  localparam logic [2:0] OP_FMA   = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_SQRT  = 3'd4;
  localparam logic [2:0] OP_SGNJ  = 3'd5;
  localparam logic [2:0] OP_SGNJN = 3'd6;

  localparam int CNT_MAX = (DIV_TIMEOUT > PIPE_LAT) ? DIV_TIMEOUT : PIPE_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] PIPE_SAMPLE = CNT_W'(PIPE_LAT);
  localparam logic [CNT_W-1:0] DIV_LAST    = CNT_W'(DIV_TIMEOUT - 1);

  localparam logic [FPLEN-1:0] CANON_NAN = FPLEN'(32'h7FC0_0000);
  localparam logic [4:0]       FLAG_NV   = 5'b10000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PIPE,
    ST_DIVSQRT,
    ST_DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;

  // operation captured at issue
  logic [2:0]        op_reg;
  logic [2:0]        rnd_reg;
  logic [4:0]        fd_reg;
  logic [FPLEN-1:0]  a_reg;
  logic [FPLEN-1:0]  b_reg;
  logic [FPLEN-1:0]  c_reg;

  // writeback registers, loaded only on the edge entering DONE
  logic [FPLEN-1:0]  res_reg, res_next;
  logic [4:0]        flags_reg, flags_next;
  logic [4:0]        out_fd_reg, out_fd_next;

  // remembers that the current DONE came from DIVSQRT (halt extends into it)
  logic              from_div_reg;

  logic              issue_accept;
  logic              sgnj_sign;

  assign issue_accept = (state_reg == ST_IDLE) && bus.issue_valid;

  // sign for the sign-injection family, from the live issue operands
  always_comb begin
    sgnj_sign = bus.fs1_data[FPLEN-1] ^ bus.fs2_data[FPLEN-1];
    if (bus.issue_op == OP_SGNJ) begin
      sgnj_sign = bus.fs2_data[FPLEN-1];
    end else if (bus.issue_op == OP_SGNJN) begin
      sgnj_sign = ~bus.fs2_data[FPLEN-1];
    end
  end

  // ---------------------------------------------------------------------
  // state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // ---------------------------------------------------------------------
  // next-state, counter and writeback selection
  // ---------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    res_next    = res_reg;
    flags_next  = flags_reg;
    out_fd_next = out_fd_reg;

    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        if (bus.issue_valid) begin
          if (bus.issue_op >= OP_SGNJ) begin
            state_next  = ST_DONE;
            res_next    = {sgnj_sign, bus.fs1_data[FPLEN-2:0]};
            flags_next  = '0;
            out_fd_next = bus.issue_fd;
          end else if (bus.issue_op >= OP_DIV) begin
            state_next = ST_DIVSQRT;
          end else begin
            state_next = ST_PIPE;
          end
        end
      end

      // cnt_reg is 0 in the pipe_start cycle, so PIPE_LAT marks the
      // cycle whose response belongs to this operation
      ST_PIPE: begin
        if (cnt_reg == PIPE_SAMPLE) begin
          state_next  = ST_DONE;
          cnt_next    = '0;
          res_next    = bus.pipe_result;
          flags_next  = bus.pipe_flags;
          out_fd_next = fd_reg;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      // done is ignored in the start cycle (cnt_reg == 0); a done in the
      // last allowed cycle still wins over the timeout
      ST_DIVSQRT: begin
        if ((cnt_reg != '0) && bus.divsqrt_done) begin
          state_next  = ST_DONE;
          cnt_next    = '0;
          res_next    = bus.divsqrt_result;
          flags_next  = bus.divsqrt_flags;
          out_fd_next = fd_reg;
        end else if (cnt_reg == DIV_LAST) begin
          state_next  = ST_DONE;
          cnt_next    = '0;
          res_next    = CANON_NAN;
          flags_next  = FLAG_NV;
          out_fd_next = fd_reg;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end

      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // issue capture and writeback registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg       <= '0;
      rnd_reg      <= '0;
      fd_reg       <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      c_reg        <= '0;
      res_reg      <= '0;
      flags_reg    <= '0;
      out_fd_reg   <= '0;
      from_div_reg <= 1'b0;
    end else begin
      if (issue_accept) begin
        op_reg  <= bus.issue_op;
        rnd_reg <= bus.issue_rnd;
        fd_reg  <= bus.issue_fd;
        a_reg   <= bus.fs1_data;
        b_reg   <= (bus.issue_op == OP_SQRT) ? '0 : bus.fs2_data;
        c_reg   <= (bus.issue_op == OP_FMA)  ? bus.fs3_data : '0;
      end
      res_reg      <= res_next;
      flags_reg    <= flags_next;
      out_fd_reg   <= out_fd_next;
      from_div_reg <= (state_reg == ST_DIVSQRT);
    end
  end

  // ---------------------------------------------------------------------
  // outputs
  // ---------------------------------------------------------------------
  assign bus.issue_ready = (state_reg == ST_IDLE);
  assign bus.busy        = (state_reg != ST_IDLE);

  // start strobes fire in the first cycle of their state (counter still 0)
  assign bus.pipe_start  = (state_reg == ST_PIPE) && (cnt_reg == '0);
  assign bus.pipe_op     = (op_reg == OP_MUL) ? 2'd1 :
                           (op_reg == OP_FMA) ? 2'd2 :
                           (op_reg == OP_ADD) ? 2'd0 : 2'd0;
  assign bus.pipe_a      = a_reg;
  assign bus.pipe_b      = b_reg;
  assign bus.pipe_c      = c_reg;
  assign bus.pipe_rnd    = rnd_reg;

  assign bus.divsqrt_start   = (state_reg == ST_DIVSQRT) && (cnt_reg == '0);
  assign bus.divsqrt_is_sqrt = (state_reg == ST_DIVSQRT) && (op_reg == OP_SQRT);

  assign bus.fpu_complete = (state_reg == ST_DONE);
  assign bus.fpu_result_1 = res_reg;
  assign bus.fpu_fd       = out_fd_reg;
  assign bus.fpu_flags    = flags_reg;

  assign bus.halt_req = (state_reg == ST_DIVSQRT) ||
                        ((state_reg == ST_DONE) && from_div_reg);

endmodule

// File: doc/fpu_exec_responder.md
FPU_EXEC_RESPONDER -- requirements
Module: fpu_exec_responder

Interface
REQ-001 SHALL have parameters: FPLEN, 32, operand/result width; PIPE_LAT, 3, fixed add/mul/fma pipe latency in cycles (>=1); DIV_TIMEOUT, 64, max cycles to wait for div/sqrt done.
REQ-002 SHALL use one clock and a synchronous, active-high reset; ports (name dir width meaning):
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 issue_valid  in  1  operation issue strobe from FPU decode.
REQ-006 issue_op  in  3  0 ADD, 1 MUL, 2 FMA, 3 DIV, 4 SQRT, 5 SGNJ, 6 SGNJN, 7 SGNJX.
REQ-007 issue_rnd  in  3  rounding mode; issue_fd  in  5  destination FP register.
REQ-008 fs1_data, fs2_data, fs3_data  in  FPLEN each  source operands.
REQ-009 issue_ready  out  1  high only in IDLE.
REQ-010 pipe_start out 1; pipe_op out 2 (0 add, 1 mul, 2 fma); pipe_a/pipe_b/pipe_c out FPLEN; pipe_rnd out 3: pipelined-unit request.
REQ-011 pipe_result in FPLEN; pipe_flags in 5: pipelined-unit response.
REQ-012 divsqrt_start out 1; divsqrt_is_sqrt out 1; divsqrt_done in 1; divsqrt_result in FPLEN; divsqrt_flags in 5.
REQ-013 fpu_complete out 1; fpu_result_1 out FPLEN; fpu_fd out 5; fpu_flags out 5 {NV,DZ,OF,UF,NX}: writeback to decode/register file.
REQ-014 halt_req out 1 (core stall during div/sqrt); busy out 1 (state != IDLE).

Function
REQ-015 SHALL implement states IDLE, PIPE, DIVSQRT, DONE.
REQ-016 Issue accepted only when issue_valid=1 in IDLE; op, rnd, fd, operands captured at that edge; issue_valid outside IDLE SHALL be ignored with no state change.
REQ-017 ops 5-7: IDLE->DONE; result {sgn, fs1[30:0]}, sgn = fs2[31] / ~fs2[31] / fs1[31]^fs2[31]; flags 0.
REQ-018 ops 0-2: IDLE->PIPE; pipe_start one-cycle pulse in first PIPE cycle with registered operands (FMA uses pipe_c=fs3; ADD/MUL drive pipe_c=0).
REQ-019 pipe_result/pipe_flags SHALL be sampled exactly PIPE_LAT cycles after the pipe_start cycle, then PIPE->DONE.
REQ-020 ops 3-4: IDLE->DIVSQRT; divsqrt_start one-cycle pulse in first DIVSQRT cycle, divsqrt_is_sqrt=1 for op 4 and held through DIVSQRT (SQRT uses fs1 only).
REQ-021 divsqrt_done sampled from the cycle after divsqrt_start; on done, result/flags captured, DIVSQRT->DONE.
REQ-022 Counter SHALL count DIVSQRT cycles; if done not seen after DIV_TIMEOUT cycles: result 32'h7FC00000, flags 5'b10000, DIVSQRT->DONE.
REQ-023 divsqrt_done outside DIVSQRT, and pipe_result outside the sample cycle, SHALL be ignored.
REQ-024 DONE lasts exactly one cycle: fpu_complete=1, then DONE->IDLE unconditionally.
REQ-025 fpu_result_1, fpu_fd, fpu_flags SHALL update at the edge entering DONE and hold until the next completion.
REQ-026 halt_req=1 in DIVSQRT and in a DONE reached from DIVSQRT, else 0.
REQ-027 Latencies (issue in cycle N): sign-inject complete in N+1; pipe ops complete in N+2+PIPE_LAT; div/sqrt complete one cycle after done sampled.
REQ-028 Back-to-back: next issue accepted in the cycle after DONE (IDLE); at most one op in flight.

Reset
REQ-029 rst=1 SHALL force IDLE, counters 0; all outputs 0 except issue_ready=1; effective at the next edge, including mid-operation.
REQ-030 Operation aborted by reset SHALL produce no fpu_complete; a late divsqrt_done after reset SHALL be ignored.

Verification
REQ-031 SGNJX issue fs1=32'hBF800000, fs2=32'h80000000, fd=3 -> complete in N+1, result 32'h3F800000, fpu_fd=3, flags 0.
REQ-032 ADD, PIPE_LAT=3, pipe_result=32'h40400000 flags 5'b00001 in pipe_start cycle+3 -> complete in N+5 with those values; one pipe_start pulse only.
REQ-033 DIV, divsqrt_done at 10th DIVSQRT cycle, result 32'h3F000000 -> halt_req high throughout incl. complete cycle, result latched, halt_req 0 after.
REQ-034 SQRT, divsqrt_done never asserted -> complete after 64 DIVSQRT cycles, result 32'h7FC00000, flags 5'b10000.
REQ-035 Second issue_valid during PIPE ignored; rst mid-DIVSQRT then divsqrt_done -> no fpu_complete, outputs 0, issue_ready=1.
